// File: rtl/tdc_meas_sequencer.sv
// -----------------------------------------------------------------------------
// tdc_meas_sequencer
//   Single-clock measurement sequencer for the TDC core. For each sample it
//   issues a one-cycle launch strobe, waits cap_delay idle cycles, issues a
//   one-cycle capture strobe, waits SETTLE cycles for the synchronised
//   population count (hw_in) to become valid, then folds the saturated sample
//   into running sum/min/max and flips pg_tog. After n_samples samples the
//   result is offered on a valid/ready handshake.
//
//   Handshake: res_valid rises in DONE and stays high, with res_sum/res_min/
//   res_max stable, until a cycle where res_valid & res_ready are both 1; that
//   cycle is the transfer and the sequencer is back in IDLE on the next cycle.
//
// Ports
//   clk, rst_n        system clock, asynchronous active-low reset
//   start             run request, honoured only in IDLE with n_samples != 0
//   abort             synchronous cancel (ignored in IDLE and DONE)
//   n_samples         samples per run, latched at accepted start
//   cap_delay         idle cycles between launch and capture, latched at start
//   busy              run in progress (any state except IDLE)
//   clk_launch        one-cycle launch strobe
//   clk_capture       one-cycle capture strobe
//   pg_tog            pulse-generator toggle, flips once per completed sample
//   hw_in             TDC population count
//   res_valid/ready   result handshake
//   res_sum/min/max   run result (hold until the next accepted start)
//   dbg_state         current FSM state for observation
// -----------------------------------------------------------------------------
module tdc_meas_sequencer #(
   parameter int N      = 64,
   parameter int N_O    = $clog2(N),
   parameter int CNT_W  = 16,
   parameter int DLY_W  = 4,
   parameter int SETTLE = 3,
   parameter int ACC_W  = N_O + 1 + CNT_W
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               start,
   input  logic               abort,
   input  logic [CNT_W-1:0]   n_samples,
   input  logic [DLY_W-1:0]   cap_delay,
   output logic               busy,
   output logic               clk_launch,
   output logic               clk_capture,
   output logic               pg_tog,
   input  logic [N_O:0]       hw_in,
   output logic               res_valid,
   input  logic               res_ready,
   output logic [ACC_W-1:0]   res_sum,
   output logic [N_O:0]       res_min,
   output logic [N_O:0]       res_max,
   output logic [2:0]         dbg_state
);

   localparam int HW_W  = N_O + 1;
   localparam int SET_W = $clog2(SETTLE + 1);

   typedef enum logic [2:0] {
      S_IDLE    = 3'd0,
      S_LAUNCH  = 3'd1,
      S_GAP     = 3'd2,
      S_CAPTURE = 3'd3,
      S_SETTLE  = 3'd4,
      S_ACCUM   = 3'd5,
      S_DONE    = 3'd6
   } state_t;

   state_t             state_q;
   logic [CNT_W-1:0]   n_q;
   logic [CNT_W-1:0]   cnt_q;
   logic [DLY_W-1:0]   dly_q;
   logic [DLY_W-1:0]   gap_cnt_q;
   logic [SET_W-1:0]   set_cnt_q;
   logic               busy_q;
   logic               launch_q;
   logic               capture_q;
   logic               pg_tog_q;
   logic               valid_q;
   logic [ACC_W-1:0]   sum_q;
   logic [HW_W-1:0]    min_q;
   logic [HW_W-1:0]    max_q;

   // Sample value clamped to the physical delay-line length.
   logic [HW_W-1:0]    samp_d;
   logic               abortable_d;

   always_comb begin
      samp_d      = (hw_in > HW_W'(N)) ? HW_W'(N) : hw_in;
      abortable_d = (state_q != S_IDLE) && (state_q != S_DONE);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         n_q       <= '0;
         cnt_q     <= '0;
         dly_q     <= '0;
         gap_cnt_q <= '0;
         set_cnt_q <= '0;
         busy_q    <= 1'b0;
         launch_q  <= 1'b0;
         capture_q <= 1'b0;
         pg_tog_q  <= 1'b0;
         valid_q   <= 1'b0;
         sum_q     <= '0;
         min_q     <= HW_W'(N);
         max_q     <= '0;
      end else begin
         // Strobes are single-cycle; they are re-asserted only on entry.
         launch_q  <= 1'b0;
         capture_q <= 1'b0;
         if (abort && abortable_d) begin
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
         end else begin
            case (state_q)
               S_IDLE: begin
                  if (start && (n_samples != '0)) begin
                     n_q      <= n_samples;
                     dly_q    <= cap_delay;
                     cnt_q    <= '0;
                     sum_q    <= '0;
                     min_q    <= HW_W'(N);
                     max_q    <= '0;
                     busy_q   <= 1'b1;
                     launch_q <= 1'b1;
                     state_q  <= S_LAUNCH;
                  end
               end
               S_LAUNCH: begin
                  if (dly_q != '0) begin
                     gap_cnt_q <= DLY_W'(1);
                     state_q   <= S_GAP;
                  end else begin
                     capture_q <= 1'b1;
                     state_q   <= S_CAPTURE;
                  end
               end
               S_GAP: begin
                  // gap_cnt_q numbers the GAP cycles 1..dly_q.
                  if (gap_cnt_q == dly_q) begin
                     capture_q <= 1'b1;
                     state_q   <= S_CAPTURE;
                  end else begin
                     gap_cnt_q <= gap_cnt_q + DLY_W'(1);
                  end
               end
               S_CAPTURE: begin
                  set_cnt_q <= SET_W'(1);
                  state_q   <= S_SETTLE;
               end
               S_SETTLE: begin
                  if (set_cnt_q == SET_W'(SETTLE)) begin
                     state_q <= S_ACCUM;
                  end else begin
                     set_cnt_q <= set_cnt_q + SET_W'(1);
                  end
               end
               S_ACCUM: begin
                  sum_q    <= sum_q + ACC_W'(samp_d);
                  if (samp_d < min_q) min_q <= samp_d;
                  if (samp_d > max_q) max_q <= samp_d;
                  cnt_q    <= cnt_q + CNT_W'(1);
                  pg_tog_q <= ~pg_tog_q;
                  if ((cnt_q + CNT_W'(1)) == n_q) begin
                     valid_q <= 1'b1;
                     state_q <= S_DONE;
                  end else begin
                     launch_q <= 1'b1;
                     state_q  <= S_LAUNCH;
                  end
               end
               S_DONE: begin
                  if (res_ready) begin
                     valid_q <= 1'b0;
                     busy_q  <= 1'b0;
                     state_q <= S_IDLE;
                  end
               end
               default: begin
                  busy_q  <= 1'b0;
                  valid_q <= 1'b0;
                  state_q <= S_IDLE;
               end
            endcase
         end
      end
   end

   assign busy        = busy_q;
   assign clk_launch  = launch_q;
   assign clk_capture = capture_q;
   assign pg_tog      = pg_tog_q;
   assign res_valid   = valid_q;
   assign res_sum     = sum_q;
   assign res_min     = min_q;
   assign res_max     = max_q;
   assign dbg_state   = state_q;

endmodule
